// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS memory stage sitting behind execute.
// Runs a req/ack data-bus transaction for loads and stores, aligns and
// extends load data, forwards ALU results, and stalls upstream while a bus
// access is outstanding.
// Optional: define MEM_TIMEOUT_EN to abort bus accesses after TIMEOUT wait cycles.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] Alu_resultado,
    input  logic [31:0] Dato_2,
    input  logic        reg_write_in,
    input  logic [4:0]  wb_reg_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] result_out,
    output logic        reg_write_out,
    output logic [4:0]  wb_reg_out,
    output logic        misaligned,
    output logic        access_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_next;
    logic        is_mem, illegal_op, unaligned_op, accept, timeout;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_unsigned, lat_load, lat_we, lat_rw;
    logic [4:0]  lat_wb;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;

    // Little-endian byte-enable pattern for the access
    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   calc_be = 4'b0001 << lane;
            2'b01:   calc_be = 4'b0011 << {lane[1], 1'b0};
            default: calc_be = 4'b1111;
        endcase
    endfunction

    // Replicate store data across every lane it may land in
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   calc_wdata = {4{data[7:0]}};
            2'b01:   calc_wdata = {2{data[15:0]}};
            default: calc_wdata = data;
        endcase
    endfunction

    // Pick the addressed byte/half out of the bus word and extend it
    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [1:0] lane, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*lane +: 8];
        h = rdata[16*lane[1] +: 16];
        case (size)
            2'b00:   load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extend = rdata;
        endcase
    endfunction

    assign is_mem       = mem_read | mem_write;
    assign illegal_op   = is_mem & ((mem_size == 2'b11) | (mem_read & mem_write));
    assign unaligned_op = is_mem & ~illegal_op &
                          (((mem_size == 2'b01) & Alu_resultado[0]) |
                           ((mem_size == 2'b10) & (|Alu_resultado[1:0])));
    assign accept       = (state == IDLE) & in_valid & is_mem & ~illegal_op & ~unaligned_op;

    assign bus_we    = bus_req & lat_we;
    assign bus_addr  = {lat_addr[31:2], 2'b00};
    assign bus_be    = lat_be;
    assign bus_wdata = lat_wdata;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timeout = (state == REQ) & ~bus_ack & (wait_cnt == 8'(TIMEOUT - 1));

    // Wait-state counter: cleared on entry to REQ, counts un-acked REQ cycles
    always_ff @(posedge clk) begin
        if (reset)                     wait_cnt <= 8'd0;
        else if (accept)               wait_cnt <= 8'd0;
        else if (state == REQ && !bus_ack) wait_cnt <= wait_cnt + 8'd1;
    end

    // Timeout error pulse
    always_ff @(posedge clk) begin
        if (reset) bus_err <= 1'b0;
        else       bus_err <= timeout;
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and combinational bus/stall control
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        bus_req    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                if (bus_ack)      state_next = DONE;
                else if (timeout) state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the accepted memory instruction; held stable through REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr <= 32'd0; lat_size <= 2'd0; lat_unsigned <= 1'b0; lat_load <= 1'b0;
            lat_we <= 1'b0; lat_rw <= 1'b0; lat_wb <= 5'd0; lat_be <= 4'd0; lat_wdata <= 32'd0;
        end else if (accept) begin
            lat_addr     <= Alu_resultado;
            lat_size     <= mem_size;
            lat_unsigned <= mem_unsigned;
            lat_load     <= mem_read;
            lat_we       <= mem_write;
            lat_rw       <= reg_write_in;
            lat_wb       <= wb_reg_in;
            lat_be       <= calc_be(mem_size, Alu_resultado[1:0]);
            lat_wdata    <= calc_wdata(mem_size, Dato_2);
        end
    end

    // Write-back outputs and one-cycle error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0; result_out <= 32'd0; reg_write_out <= 1'b0;
            wb_reg_out <= 5'd0; misaligned <= 1'b0; access_err <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    valid_out     <= in_valid & ~accept;
                    reg_write_out <= 1'b0;
                    if (in_valid && !accept) begin
                        result_out <= Alu_resultado;
                        wb_reg_out <= wb_reg_in;
                        if (illegal_op)        access_err    <= 1'b1;
                        else if (unaligned_op) misaligned    <= 1'b1;
                        else                   reg_write_out <= reg_write_in;
                    end
                end
                REQ: begin
                    valid_out     <= 1'b0;
                    reg_write_out <= 1'b0;
                    if (bus_ack) begin
                        valid_out     <= 1'b1;
                        result_out    <= lat_load ? load_extend(lat_size, lat_unsigned, lat_addr[1:0], bus_rdata)
                                                  : lat_addr;
                        reg_write_out <= lat_load & lat_rw;
                        wb_reg_out    <= lat_wb;
                    end else if (timeout) begin
                        valid_out  <= 1'b1;
                        result_out <= 32'd0;
                    end
                end
                default: begin
                    valid_out     <= 1'b0;
                    reg_write_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: vector table plus hand-written sequences,
// with a scoreboard queue of expected write-back records.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset, in_valid, mem_read, mem_write, mem_unsigned, reg_write_in;
    logic [1:0]  mem_size;
    logic [31:0] Alu_resultado, Dato_2;
    logic [4:0]  wb_reg_in;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        stall, valid_out, reg_write_out, misaligned, access_err, bus_err;
    logic [31:0] result_out;
    logic [4:0]  wb_reg_out;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .Alu_resultado(Alu_resultado), .Dato_2(Dato_2), .reg_write_in(reg_write_in),
        .wb_reg_in(wb_reg_in), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall(stall), .valid_out(valid_out), .result_out(result_out),
        .reg_write_out(reg_write_out), .wb_reg_out(wb_reg_out), .misaligned(misaligned),
        .access_err(access_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rd; logic wr; logic [1:0] size; logic uns;
        logic [31:0] alu; logic [31:0] dato; logic rw; logic [4:0] wb;
        logic req; int ack_at; logic [31:0] rdata;
        logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
        logic [31:0] res; logic rw_o; logic mis; logic aerr;
    } vec_t;

    typedef struct {
        logic [31:0] res; logic rw; logic [4:0] wb; logic mis; logic aerr; logic cmp_res;
    } exp_t;

    int     checks = 0;
    int     failures = 0;
    exp_t   sb[$];
    vec_t   vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mem_read = v.rd; mem_write = v.wr; mem_size = v.size; mem_unsigned = v.uns;
        Alu_resultado = v.alu; Dato_2 = v.dato; reg_write_in = v.rw; wb_reg_in = v.wb;
        in_valid = 1'b1;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.res = v.res; e.rw = v.rw_o; e.wb = v.wb; e.mis = v.mis; e.aerr = v.aerr;
        e.cmp_res = !(v.mis || v.aerr);
        sb.push_back(e);
    endtask

    task automatic retire_check(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_scoreboard actual=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.cmp_res) chk({tag, "_result"}, result_out, e.res);
            chk({tag, "_regwrite"}, 32'(reg_write_out), 32'(e.rw));
            chk({tag, "_wbreg"}, 32'(wb_reg_out), 32'(e.wb));
            chk({tag, "_misaligned"}, 32'(misaligned), 32'(e.mis));
            chk({tag, "_accesserr"}, 32'(access_err), 32'(e.aerr));
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Issue one vector from IDLE and follow it to retirement; entry/exit at posedge+1
    task automatic run_vec(input string tag, input vec_t v);
        int  stall_cnt;
        int  reqc;
        bit  done;
        drive(v);
        push_exp(v);
        #1;
        chk({tag, "_stall_issue"}, 32'(stall), 32'(v.req));
        chk({tag, "_req_issue"}, 32'(bus_req), 32'd0);
        stall_cnt = int'(stall);
        if (v.req) begin
            reqc = 0;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(posedge clk); #1;
                stall_cnt += int'(stall);
                if (bus_req) begin
                    reqc++;
                    if (reqc == 1 || reqc == v.ack_at) begin
                        chk({tag, "_we"}, 32'(bus_we), 32'(v.we));
                        chk({tag, "_addr"}, bus_addr, v.addr);
                        chk({tag, "_be"}, 32'(bus_be), 32'(v.be));
                        chk({tag, "_wdata"}, bus_wdata, v.wdata);
                    end
                    if (reqc == v.ack_at) begin
                        bus_ack = 1'b1; bus_rdata = v.rdata;
                        @(posedge clk); #1;
                        bus_ack = 1'b0; bus_rdata = 32'hA5A5A5A5;
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                checks++; failures++;
                $display("FAIL %s_req_wait actual=no_req expected=req", tag);
            end
            chk({tag, "_stall_done"}, 32'(stall), 32'd0);
            chk({tag, "_req_done"}, 32'(bus_req), 32'd0);
            chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(v.ack_at + 1));
        end else begin
            @(posedge clk); #1;
            chk({tag, "_req_none"}, 32'(bus_req), 32'd0);
            chk({tag, "_stall_none"}, 32'(stall), 32'd0);
        end
        retire_check(tag);
        idle_inputs();
        @(posedge clk); #1;
        chk({tag, "_valid_after"}, 32'(valid_out), 32'd0);
        chk({tag, "_pulse_once"}, 32'({misaligned, access_err}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
        idle_inputs(); mem_size = 2'b00; mem_unsigned = 1'b0;
        Alu_resultado = 32'd0; Dato_2 = 32'd0; reg_write_in = 1'b0; wb_reg_in = 5'd0;

        //          rd   wr   size  uns  alu           dato          rw   wb     req ack rdata         we   addr         be     wdata         res           rw_o mis  aerr
        vecs[0]  = '{1'b0,1'b1,2'b10,1'b0,32'h10,      32'hDEADBEEF,1'b1,5'd9,  1'b1,2,32'h0,        1'b1,32'h10,      4'hF,  32'hDEADBEEF, 32'h10,      1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,2'b00,1'b0,32'h13,      32'h0,       1'b1,5'd7,  1'b1,1,32'h80FF0000, 1'b0,32'h10,      4'h8,  32'h0,        32'hFFFFFF80,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,2'b00,1'b1,32'h13,      32'h0,       1'b1,5'd7,  1'b1,3,32'h80FF0000, 1'b0,32'h10,      4'h8,  32'h0,        32'h00000080,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,2'b01,1'b0,32'h2,       32'h0,       1'b1,5'd12, 1'b1,1,32'h80011234, 1'b0,32'h0,       4'hC,  32'h0,        32'hFFFF8001,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,2'b01,1'b0,32'h2,       32'h0000ABCD,1'b1,5'd12, 1'b1,1,32'h0,        1'b1,32'h0,       4'hC,  32'hABCDABCD, 32'h2,       1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,2'b00,1'b0,32'h21,      32'h12345678,1'b0,5'd0,  1'b1,1,32'h0,        1'b1,32'h20,      4'h2,  32'h78787878, 32'h21,      1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,2'b10,1'b0,32'h6,       32'h0,       1'b1,5'd4,  1'b0,0,32'h0,        1'b0,32'h0,       4'h0,  32'h0,        32'h6,       1'b0,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,2'b10,1'b0,32'h8,       32'h0,       1'b1,5'd4,  1'b0,0,32'h0,        1'b0,32'h0,       4'h0,  32'h0,        32'h8,       1'b0,1'b0,1'b1};
        vecs[8]  = '{1'b1,1'b0,2'b11,1'b0,32'h8,       32'h0,       1'b1,5'd4,  1'b0,0,32'h0,        1'b0,32'h0,       4'h0,  32'h0,        32'h8,       1'b0,1'b0,1'b1};
        vecs[9]  = '{1'b1,1'b0,2'b01,1'b1,32'h3,       32'h0,       1'b1,5'd4,  1'b0,0,32'h0,        1'b0,32'h0,       4'h0,  32'h0,        32'h3,       1'b0,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b0,2'b10,1'b0,32'h5A,      32'h0,       1'b1,5'd3,  1'b0,0,32'h0,        1'b0,32'h0,       4'h0,  32'h0,        32'h5A,      1'b1,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,2'b01,1'b1,32'h0,       32'h0,       1'b1,5'd5,  1'b1,2,32'h1234F00D, 1'b0,32'h0,       4'h3,  32'h0,        32'h0000F00D,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,2'b10,1'b0,32'h44,      32'h0,       1'b1,5'd6,  1'b1,1,32'hCAFEF00D, 1'b0,32'h44,      4'hF,  32'h0,        32'hCAFEF00D,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,2'b00,1'b0,32'hFFFFFFFF,32'h0,       1'b0,5'd31, 1'b0,0,32'h0,        1'b0,32'h0,       4'h0,  32'h0,        32'hFFFFFFFF,1'b0,1'b0,1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_regwrite", 32'(reg_write_out), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_errs", 32'({misaligned, access_err, bus_err}), 32'd0);
        reset = 1'b0;

        // Stray acknowledge and bubble in IDLE
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("stray_ack_valid", 32'(valid_out), 32'd0);
        chk("stray_ack_req", 32'(bus_req), 32'd0);
        chk("bubble_regwrite", 32'(reg_write_out), 32'd0);

        for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Back-to-back: word load, then ALU op issued right after DONE
        begin
            vec_t ld;
            vec_t alu;
            bit   done;
            ld = vecs[12];
            alu = vecs[10];
            drive(ld); push_exp(ld); push_exp(alu);
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(posedge clk); #1;
                if (bus_req) begin
                    bus_ack = 1'b1; bus_rdata = ld.rdata;
                    @(posedge clk); #1;
                    bus_ack = 1'b0;
                    done = 1'b1;
                end
            end
            if (!done) begin
                checks++; failures++;
                $display("FAIL b2b_req_wait actual=no_req expected=req");
            end
            retire_check("b2b_load");
            @(posedge clk); #1;
            drive(alu);
            #1;
            chk("b2b_alu_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            retire_check("b2b_alu");
            idle_inputs();
            @(posedge clk); #1;
        end

        // Reset asserted while a request is outstanding
        begin
            bit seen;
            drive(vecs[1]);
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(posedge clk); #1;
                seen = bus_req;
            end
            chk("rstreq_reached_req", 32'(seen), 32'd1);
            reset = 1'b1; idle_inputs();
            @(posedge clk); #1;
            reset = 1'b0;
            chk("rstreq_bus_req", 32'(bus_req), 32'd0);
            chk("rstreq_valid", 32'(valid_out), 32'd0);
            @(posedge clk); #1;
            bus_ack = 1'b1; bus_rdata = 32'h80FF0000;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            chk("rstreq_late_ack_valid", 32'(valid_out), 32'd0);
            chk("rstreq_late_ack_req", 32'(bus_req), 32'd0);
            chk("rstreq_errs", 32'({misaligned, access_err, bus_err}), 32'd0);
        end

`ifdef MEM_TIMEOUT_EN
        // No acknowledge: access is abandoned after 16 REQ cycles
        begin
            int reqc;
            bit fell;
            vec_t ld;
            ld = vecs[12];
            drive(ld);
            reqc = 0;
            fell = 1'b0;
            for (int c = 0; c < 40 && !fell; c++) begin
                @(posedge clk); #1;
                if (bus_req) reqc++;
                else if (reqc > 0) fell = 1'b1;
            end
            idle_inputs();
            chk("to_req_cycles", 32'(reqc), 32'd16);
            chk("to_bus_err", 32'(bus_err), 32'd1);
            chk("to_valid", 32'(valid_out), 32'd1);
            chk("to_result", result_out, 32'd0);
            chk("to_regwrite", 32'(reg_write_out), 32'd0);
            #1;
            chk("to_idle_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk("to_err_once", 32'(bus_err), 32'd0);
            chk("to_idle_req", 32'(bus_req), 32'd0);
        end
`else
        chk("no_timeout_bus_err", 32'(bus_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage that sits directly downstream of the execute stage of the MIPS pipeline.
- Takes the ALU result as the effective address and the second operand as store data, then runs a request/acknowledge transaction on the data-memory bus.
- Aligns and sign- or zero-extends load data, and passes non-memory results through to write-back.
- Drives a stall to freeze the upstream pipeline while a bus access is outstanding.

Parameters:
- TIMEOUT, 16: bus wait-state limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an instruction is present from execute; low means bubble.
- mem_read  input  1  instruction is a load.
- mem_write  input  1  instruction is a store.
- mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- mem_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
- Alu_resultado  input  32  effective address, or the result for non-memory instructions.
- Dato_2  input  32  store data.
- reg_write_in  input  1  instruction writes a register.
- wb_reg_in  input  5  destination register number.
- bus_req  output  1  memory request.
- bus_we  output  1  write strobe.
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_ack  input  1  memory completed the access this cycle.
- bus_rdata  input  32  read data; valid only when bus_ack is high.
- stall  output  1  freeze execute and earlier stages (combinational).
- valid_out  output  1  one instruction retires to write-back this cycle.
- result_out  output  32  write-back data.
- reg_write_out  output  1  write-back enable.
- wb_reg_out  output  5  write-back register number.
- misaligned  output  1  one-cycle pulse: misaligned access dropped.
- access_err  output  1  one-cycle pulse: illegal access dropped.
- bus_err  output  1  one-cycle pulse: bus timeout (tied 0 when the macro is undefined).

Behaviour:
- Reset: state IDLE. All registered outputs 0, bus_req 0. Any bus_ack arriving after reset is ignored.
- FSM states are IDLE, REQ and DONE.
- IDLE, with in_valid and no memory operation: on the next edge, valid_out=1, result_out=Alu_resultado, and reg_write_out/wb_reg_out follow their inputs. Latency is 1 cycle; stall=0.
- IDLE, with in_valid and mem_read or mem_write, legal and aligned:
  - stall=1 combinationally in this cycle.
  - Latch address, be, wdata, size, unsigned, reg_write_in and wb_reg_in.
  - Next state is REQ.
- REQ:
  - bus_req=1 with the latched bus_we/bus_addr/bus_be/bus_wdata, held stable until bus_ack.
  - stall=1.
  - On bus_ack: capture the load data (or Alu address for stores) into result_out and go to DONE.
- DONE:
  - bus_req=0, stall=0, valid_out=1.
  - reg_write_out is the latched reg_write_in for loads and 0 for stores.
  - Inputs are ignored, because they still hold the same stalled instruction.
  - Unconditional transition to IDLE.
- Timing summary: a memory access with acknowledge on the n-th REQ cycle holds stall high for n+1 cycles; valid_out is high in the cycle after the acknowledge.
- Alignment rules: half requires addr[0]=0; word requires addr[1:0]=00.
  - On violation: misaligned pulses on the next edge, with no bus access, no stall, and valid_out=1 with reg_write_out=0.
- Illegal access: mem_size=11, or mem_read and mem_write both high.
  - access_err pulses on the next edge; otherwise handled the same way as a misaligned access.
- Byte enables and store data (little-endian):
  - Byte: be = 0001<<addr[1:0], wdata = {4{Dato_2[7:0]}}.
  - Half: be = 0011<<{addr[1],1'b0}, wdata = {2{Dato_2[15:0]}}.
  - Word: be = 1111, wdata = Dato_2.
- Load extraction:
  - Byte: bus_rdata[8*addr[1:0]+:8].
  - Half: bus_rdata[16*addr[1]+:16].
  - Extension is zero when mem_unsigned=1, sign otherwise.
- in_valid=0 in IDLE: valid_out=0 and reg_write_out=0 on the next edge, with no other effect.
- Reset during REQ: bus_req falls in the following cycle, no retirement, no error pulse.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to REQ and increments each REQ cycle without bus_ack.
  - When it reaches TIMEOUT-1 without acknowledge: drop bus_req, pulse bus_err, set result_out=0 and reg_write_out=0, assert valid_out, and go to IDLE.
  - bus_ack takes priority when it coincides with the timeout cycle.
- Undefined: no counter, bus_err tied 0, and REQ waits indefinitely.

Test Plan:
- Word store, addr 0x10, Dato_2 0xDEADBEEF, bus_ack on the 2nd REQ cycle -> bus_we=1, bus_be=1111, bus_wdata=0xDEADBEEF, stall high exactly 3 cycles, valid_out=1 with reg_write_out=0.
- Byte load, addr 0x13, bus_rdata 0x80FF0000 -> result_out 0xFFFFFF80 when signed, 0x00000080 when mem_unsigned=1, bus_addr 0x10, reg_write_out=1, wb_reg_out=wb_reg_in.
- Half load, addr 0x2, bus_rdata 0x80011234 -> result_out 0xFFFF8001; with a store of 0xABCD to the same address -> be=1100, wdata 0xABCDABCD.
- Word load at addr 0x6 -> misaligned pulses once, bus_req stays 0, stall 0, reg_write_out 0. mem_read and mem_write both high -> access_err pulse.
- Non-memory instruction, Alu_resultado 0x5A -> next cycle valid_out=1, result_out 0x5A, stall never asserted. Back-to-back load followed by ALU op retires in order.
- Reset asserted in REQ, ack 2 cycles later -> bus_req 0 after reset, no valid_out. With MEM_TIMEOUT_EN and TIMEOUT=16, no ack -> bus_err pulse after 16 REQ cycles, state IDLE.
